spi_dopi_rd_seq: RTL and testbench

- Command/read sequencer that sits directly upstream of the octal DDR SPI (DOPI) PHY driving the MX66UM1G45G-class flash.
- Accepts word-read requests, emits per-SCLK-cycle CS#, clock-enable and rise/fall output bytes for the 8DTRD (EEh/11h) command, 4-byte address and dummy phases.
- Assembles the DQS-captured rise/fall byte pairs returned by the PHY into 32-bit words.
- One sysclk cycle equals one SCLK cycle at the PHY.

---
 rtl/spi_dopi_rd_seq.sv | 168 ++++++++++++++++
 tb/tb_spi_dopi_rd_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_dopi_rd_seq.sv
// spi_dopi_rd_seq: 8DTRD (EEh/11h) read sequencer for an octal DDR SPI (DOPI) PHY.
// Emits per-SCLK CS#/clock-enable/output bytes and assembles DQS beats into 32-bit words.
// Optional idle-data watchdog: define SPI_DOPI_TIMEOUT_EN.
module spi_dopi_rd_seq #(
   parameter int unsigned DUMMY_CYCLES   = 20,
   parameter int unsigned LEN_W          = 8,
   parameter int unsigned CS_GAP         = 2,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_addr,
   input  logic [LEN_W-1:0] req_len,
   output logic [31:0]      rdata,
   output logic             rdata_valid,
   output logic             done,
   output logic             err,
   output logic             busy,
   output logic             cs_n,
   output logic             sclk_en,
   output logic             dq_oe,
   output logic [7:0]       dq_o_rise,
   output logic [7:0]       dq_o_fall,
   input  logic [7:0]       dq_i_rise,
   input  logic [7:0]       dq_i_fall,
   input  logic             dq_i_valid
);

   localparam int unsigned CNT_W = LEN_W + 1;
   localparam int unsigned PH_W  = (CNT_W > 8) ? CNT_W : 8;
   localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
`ifdef SPI_DOPI_TIMEOUT_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   typedef enum logic [3:0] {
      S_IDLE, S_CS_SETUP, S_CMD, S_ADDR0, S_ADDR1,
      S_DUMMY, S_DATA, S_WAIT, S_CS_HOLD, S_GAP
   } state_t;

   state_t            state, state_d;
   logic [31:0]       addr_q;
   logic [LEN_W-1:0]  len_q;
   logic [PH_W-1:0]   ph_cnt, ph_cnt_d;
   logic [CNT_W-1:0]  beat_cnt, word_cnt, words_d, len2, len_ext;
   logic [WD_W-1:0]   wd_cnt;
   logic [15:0]       lo_half;
   logic              accept, zero_req, in_data, beat_take, odd_beat, timeout;
   logic              cs_n_d, sclk_en_d, dq_oe_d;
   logic [7:0]        rise_d, fall_d;

   assign accept    = (state == S_IDLE) && req_valid && (req_len != '0);
   assign zero_req  = (state == S_IDLE) && req_valid && (req_len == '0);
   assign in_data   = (state == S_DATA) || (state == S_WAIT);
   assign len2      = {len_q, 1'b0};
   assign len_ext   = {1'b0, len_q};
   assign beat_take = in_data && dq_i_valid && (beat_cnt < len2);
   assign odd_beat  = beat_take && beat_cnt[0];
   assign words_d   = word_cnt + CNT_W'(odd_beat);
   assign timeout   = WD_EN && in_data && !dq_i_valid &&
                      (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_d;
   end

   // Next-state and decode of the per-cycle PHY controls for the upcoming state.
   always_comb begin
      state_d   = state;
      cs_n_d    = 1'b1;
      sclk_en_d = 1'b0;
      dq_oe_d   = 1'b0;
      rise_d    = 8'h00;
      fall_d    = 8'h00;
      case (state)
         S_IDLE:     if (accept) state_d = S_CS_SETUP;
         S_CS_SETUP: state_d = S_CMD;
         S_CMD:      state_d = S_ADDR0;
         S_ADDR0:    state_d = S_ADDR1;
         S_ADDR1:    state_d = S_DUMMY;
         S_DUMMY:    if (ph_cnt == PH_W'(DUMMY_CYCLES - 1)) state_d = S_DATA;
         S_DATA: begin
            if (timeout) state_d = S_CS_HOLD;
            else if (ph_cnt == PH_W'(len2 - CNT_W'(1)))
               state_d = (words_d == len_ext) ? S_CS_HOLD : S_WAIT;
         end
         S_WAIT:     if (timeout || (words_d == len_ext)) state_d = S_CS_HOLD;
         S_CS_HOLD:  state_d = S_GAP;
         S_GAP:      if (ph_cnt == PH_W'(CS_GAP - 1)) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase

      ph_cnt_d = ((state_d != state) || (state == S_IDLE)) ? '0 : ph_cnt + PH_W'(1);

      case (state_d)
         S_CS_SETUP, S_WAIT, S_CS_HOLD: cs_n_d = 1'b0;
         S_CMD: begin
            cs_n_d = 1'b0; sclk_en_d = 1'b1; dq_oe_d = 1'b1;
            rise_d = 8'hEE; fall_d = 8'h11;
         end
         S_ADDR0: begin
            cs_n_d = 1'b0; sclk_en_d = 1'b1; dq_oe_d = 1'b1;
            rise_d = addr_q[31:24]; fall_d = addr_q[23:16];
         end
         S_ADDR1: begin
            cs_n_d = 1'b0; sclk_en_d = 1'b1; dq_oe_d = 1'b1;
            rise_d = addr_q[15:8]; fall_d = addr_q[7:0];
         end
         S_DUMMY, S_DATA: begin
            cs_n_d = 1'b0; sclk_en_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Request latch, counters, beat assembly and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q      <= '0;
         len_q       <= '0;
         ph_cnt      <= '0;
         beat_cnt    <= '0;
         word_cnt    <= '0;
         wd_cnt      <= '0;
         lo_half     <= '0;
         cs_n        <= 1'b1;
         sclk_en     <= 1'b0;
         dq_oe       <= 1'b0;
         dq_o_rise   <= '0;
         dq_o_fall   <= '0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         busy        <= 1'b0;
         req_ready   <= 1'b1;
      end else begin
         if (accept) begin
            addr_q <= {req_addr[31:2], 2'b00};
            len_q  <= req_len;
         end
         ph_cnt   <= ph_cnt_d;
         beat_cnt <= (state == S_IDLE) ? '0 : beat_cnt + CNT_W'(beat_take);
         word_cnt <= (state == S_IDLE) ? '0 : words_d;
         if (WD_EN) wd_cnt <= (in_data && !dq_i_valid) ? wd_cnt + WD_W'(1) : '0;
         if (beat_take && !beat_cnt[0]) lo_half <= {dq_i_fall, dq_i_rise};
         rdata_valid <= odd_beat;
         if (odd_beat) rdata <= {dq_i_fall, dq_i_rise, lo_half};
         done <= zero_req || (state == S_CS_HOLD);
         if (timeout)     err <= 1'b1;
         else if (accept) err <= 1'b0;
         cs_n      <= cs_n_d;
         sclk_en   <= sclk_en_d;
         dq_oe     <= dq_oe_d;
         dq_o_rise <= rise_d;
         dq_o_fall <= fall_d;
         busy      <= (state_d != S_IDLE);
         req_ready <= (state_d == S_IDLE);
      end
   end

endmodule

// File: tb/tb_spi_dopi_rd_seq.sv
// Self-checking bench for spi_dopi_rd_seq: directed table, random requests, corner sequences.
`timescale 1ns/1ps
module tb_spi_dopi_rd_seq;

   localparam int D  = 20;
   localparam int LW = 8;
   localparam int G  = 2;
   localparam int TO = 64;

   logic clk = 1'b0;
   logic rst_n, req_valid, req_ready, rdata_valid, done, err, busy;
   logic cs_n, sclk_en, dq_oe, dq_i_valid;
   logic [31:0] req_addr, rdata;
   logic [LW-1:0] req_len;
   logic [7:0] dq_o_rise, dq_o_fall, dq_i_rise, dq_i_fall;
   logic [23:0] act_w;

   always #5 clk = ~clk;

   spi_dopi_rd_seq #(
      .DUMMY_CYCLES(D), .LEN_W(LW), .CS_GAP(G), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_len(req_len), .rdata(rdata), .rdata_valid(rdata_valid),
      .done(done), .err(err), .busy(busy), .cs_n(cs_n), .sclk_en(sclk_en), .dq_oe(dq_oe),
      .dq_o_rise(dq_o_rise), .dq_o_fall(dq_o_fall), .dq_i_rise(dq_i_rise),
      .dq_i_fall(dq_i_fall), .dq_i_valid(dq_i_valid)
   );

   assign act_w = {cs_n, sclk_en, dq_oe, busy, req_ready, done, rdata_valid, err,
                   dq_o_rise, dq_o_fall};

   typedef struct {
      logic [31:0] addr;
      int          len;
      int          delay;
      int          gap_pos;
      int          gap_len;
      int          base;
      int          step;
      bit          noise;
      logic [31:0] exp_first;
      logic [31:0] exp_last;
   } vec_t;

   vec_t tbl [5];
   vec_t v;
   int checks = 0;
   int errors = 0;

   function automatic logic [7:0] bval(input int base, input int step, input int n);
      return 8'(base + step * n);
   endfunction

   function automatic logic [31:0] wval(input int base, input int step, input int j);
      return {bval(base, step, 4*j+3), bval(base, step, 4*j+2),
              bval(base, step, 4*j+1), bval(base, step, 4*j)};
   endfunction

   function automatic logic [23:0] bundle(input bit c, input bit s, input bit o, input bit b,
                                          input bit d, input bit rv, input bit e,
                                          input logic [7:0] r, input logic [7:0] f);
      return {c, s, o, b, !b, d, rv, e, r, f};
   endfunction

   // Beat index presented in cycle k of a request, or -1.
   function automatic int beat_at(input vec_t x, input int k);
      int r;
      r = k - (5 + D + x.delay);
      if (r < 0) return -1;
      if (r >= x.gap_pos) begin
         if (r < x.gap_pos + x.gap_len) return -1;
         r = r - x.gap_len;
      end
      if (r >= 2 * x.len) return -1;
      return r;
   endfunction

   task automatic chk(input string name, input int k, input logic [23:0] exp);
      checks++;
      if (act_w !== exp) begin
         errors++;
         $display("FAIL %s cyc %0d: got {cs,sclk,oe,busy,rdy,done,rv,err,rise,fall}=%h want %h",
                  name, k, act_w, exp);
      end
   endtask

   task automatic chk_w(input string name, input int k, input logic [31:0] exp);
      checks++;
      if (rdata !== exp) begin
         errors++;
         $display("FAIL %s cyc %0d: rdata got %h want %h", name, k, rdata, exp);
      end
   endtask

   task automatic chk_n(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: count got %0d want %0d", name, got, exp);
      end
   endtask

   task automatic accept_req(input logic [31:0] a, input int len);
      @(negedge clk);
      req_valid = 1'b1; req_addr = a; req_len = LW'(len);
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = $urandom; req_len = LW'($urandom);
   endtask

   // One request: timeline derived from phase lengths and beat schedule.
   task automatic run_req(input string name, input vec_t x);
      int first_k, lb, kl, hold, kend, bi, pb, nrv;
      bit rvb;
      logic [7:0] r, f;
      first_k = 5 + D + x.delay;
      lb = 2 * x.len - 1;
      kl = first_k + lb + ((lb >= x.gap_pos) ? x.gap_len : 0);
      hold = ((4 + D + 2 * x.len) > kl ? (4 + D + 2 * x.len) : kl) + 1;
      kend = hold + G + 1;
      nrv = 0;
      accept_req(x.addr, x.len);
      for (int k = 1; k <= kend; k++) begin
         bi = beat_at(x, k);
         if (bi >= 0) begin
            dq_i_valid = 1'b1;
            dq_i_rise = bval(x.base, x.step, 2*bi);
            dq_i_fall = bval(x.base, x.step, 2*bi+1);
         end else begin
            dq_i_valid = x.noise && (k < 5 + D || k > hold);
            dq_i_rise = 8'($urandom);
            dq_i_fall = 8'($urandom);
         end
         r = 8'h00; f = 8'h00;
         if (k == 2)      begin r = 8'hEE; f = 8'h11; end
         else if (k == 3) begin r = x.addr[31:24]; f = x.addr[23:16]; end
         else if (k == 4) begin r = x.addr[15:8];  f = {x.addr[7:2], 2'b00}; end
         pb = beat_at(x, k - 1);
         rvb = (pb >= 0) && (pb % 2 == 1);
         chk(name, k, bundle(k > hold, k >= 2 && k <= 4 + D + 2 * x.len, k >= 2 && k <= 4,
                             k <= hold + G, k == hold + 1, rvb, 1'b0, r, f));
         if (rvb) begin
            nrv++;
            chk_w(name, k, wval(x.base, x.step, pb / 2));
            if (pb / 2 == 0)         chk_w({name, "_first"}, k, x.exp_first);
            if (pb / 2 == x.len - 1) chk_w({name, "_last"}, k, x.exp_last);
         end
         @(posedge clk); #1;
      end
      dq_i_valid = 1'b0;
      chk_n({name, "_words"}, nrv, x.len);
   endtask

   initial begin
      tbl[0] = '{32'h0000_1237,   1, 0, 0, 0, 'h11, 'h11, 1'b0, 32'h4433_2211, 32'h4433_2211};
      tbl[1] = '{32'hA5C3_0F08,   4, 0, 0, 0, 'h00, 1,    1'b0, 32'h0302_0100, 32'h0F0E_0D0C};
      tbl[2] = '{32'h8000_0004,   2, 3, 2, 5, 'h40, 3,    1'b1, 32'h4946_4340, 32'h5552_4F4C};
      tbl[3] = '{32'hFFFF_FFFF, 255, 0, 0, 0, 'h00, 1,    1'b0, 32'h0302_0100, 32'hFBFA_F9F8};
      tbl[4] = '{32'h1234_5679,   3, 1, 5, 2, 'hF0, 1,    1'b1, 32'hF3F2_F1F0, 32'hFBFA_F9F8};

      rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0;
      dq_i_valid = 1'b0; dq_i_rise = '0; dq_i_fall = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset", 0, bundle(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
      chk_w("reset_rdata", 0, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle", 0, bundle(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));

      for (int i = 0; i < 5; i++) run_req($sformatf("tbl%0d", i), tbl[i]);

      // Zero-length request: done only, no flash activity.
      accept_req(32'h0000_0055, 0);
      chk("len0_done", 1, bundle(1, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00));
      for (int k = 2; k <= 4; k++) begin
         @(posedge clk); #1;
         chk("len0_idle", k, bundle(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
      end

      // Reset during the 10th dummy cycle, then a normal request.
      accept_req(32'hCAFE_0010, 3);
      repeat (13) @(posedge clk);
      #1;
      chk("rst_dummy", 14, bundle(0, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00));
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rst_mid", 15, bundle(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
      chk_w("rst_mid_rdata", 15, 32'h0);
      run_req("after_rst", tbl[0]);

`ifdef SPI_DOPI_TIMEOUT_EN
      // Single beat, then silence until the watchdog aborts.
      begin
         int kb, nrv;
         kb = 5 + D; nrv = 0;
         accept_req(32'h0000_0010, 1);
         for (int k = 1; k <= kb + 70; k++) begin
            dq_i_valid = (k == kb); dq_i_rise = 8'h5A; dq_i_fall = 8'hA5;
            if (rdata_valid) nrv++;
            if (k == kb + 64) chk("to_wait", k, bundle(0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00));
            if (k == kb + 65) chk("to_hold", k, bundle(0, 0, 0, 1, 0, 0, 1, 8'h00, 8'h00));
            if (k == kb + 66) chk("to_gap",  k, bundle(1, 0, 0, 1, 1, 0, 1, 8'h00, 8'h00));
            if (k == kb + 68) chk("to_idle", k, bundle(1, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00));
            @(posedge clk); #1;
         end
         dq_i_valid = 1'b0;
         chk_n("to_no_rv", nrv, 0);
         run_req("after_to", tbl[1]);
      end
`else
      // Without the watchdog WAIT holds through a long beat gap.
      v = '{32'h0000_0100, 1, 0, 1, 100, 7, 9, 1'b0, 32'h2219_1007, 32'h2219_1007};
      run_req("wait_long", v);
`endif

      for (int n = 0; n < 12; n++) begin
         v.addr      = $urandom;
         v.len       = $urandom_range(1, 8);
         v.delay     = $urandom_range(0, 5);
         v.gap_pos   = $urandom_range(0, 2 * v.len - 1);
         v.gap_len   = $urandom_range(0, 8);
         v.base      = $urandom_range(0, 255);
         v.step      = $urandom_range(1, 255);
         v.noise     = 1'($urandom_range(0, 1));
         v.exp_first = wval(v.base, v.step, 0);
         v.exp_last  = wval(v.base, v.step, v.len - 1);
         run_req($sformatf("rand%0d", n), v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
